// File: rtl/joystick_responder.sv
// Device-side responder for the serial joystick link: loads {X,Y} on latch and
// shifts it out MSB first on each synchronized pulse rising edge.
module joystick_responder #(
    parameter int   WIDTH = 8,
    parameter logic IDLE  = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             latch,
    input  logic                             pulse,
    input  logic signed [WIDTH-1:0]          positionX,
    input  logic signed [WIDTH-1:0]          positionY,
    output logic                             data_out,
    output logic [$clog2(2*WIDTH+1)-1:0]     bit_cnt,
    output logic                             frame_done
);
    localparam int            FRAME = 2 * WIDTH;
    localparam int            CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
    localparam logic [CW-1:0] FULL  = CW'(FRAME);

    logic [1:0]       latch_sync;   // {s2, s1}
    logic [2:0]       pulse_sync;   // {s3, s2, s1}
    logic             lat;
    logic             prise;
    logic [FRAME-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_sync <= '0;
            pulse_sync <= '0;
        end else begin
            latch_sync <= {latch_sync[0], latch};
            pulse_sync <= {pulse_sync[1:0], pulse};
        end
    end

    // s1 may be metastable; decisions use only s2 and the s3 history.
    assign lat   = latch_sync[1];
    assign prise = pulse_sync[1] & ~pulse_sync[2];

    // Load has priority: a pulse edge seen while latched is dropped, not queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= {FRAME{IDLE}};
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (lat) begin
            sr         <= {positionX, positionY};
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (prise) begin
            sr         <= {sr[FRAME-2:0], IDLE};
            if (bit_cnt < FULL)
                bit_cnt <= bit_cnt + CW'(1);
            frame_done <= (bit_cnt == LAST);
        end else begin
            frame_done <= 1'b0;
        end
    end

    assign data_out = sr[FRAME-1];

endmodule

// File: doc/joystick_responder.md
# joystick_responder

Device-side model of the serial joystick link: it answers the latch/pulse strobes issued by `joystick_driver` and shifts out signed X/Y positions on the data line, MSB first. It lets the game board run against a second FPGA or an in-fabric stimulus source instead of the physical controller. It sits on the `V_GPIO` side of the link: `latch` and `pulse` come in from pins, and `data_out` drives the driver's `data_in`.

## Interface
- `WIDTH`, default 8: bits per axis. One frame is 2*`WIDTH` bits.
- `IDLE`, default 1'b1: level driven on `data_out` when no frame bit is pending.

Ports:
- `clk` input, 1 bit: system clock (`CLOCK_50` at top level). All logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all state.
- `latch` input, 1 bit: load strobe from the driver. Asynchronous to `clk`.
- `pulse` input, 1 bit: shift clock from the driver. Asynchronous to `clk`.
- `positionX` input, signed `WIDTH`: X value to report. Sampled only during load.
- `positionY` input, signed `WIDTH`: Y value to report. Sampled only during load.
- `data_out` output, 1 bit: serial data to the driver. Registered.
- `bit_cnt` output, $clog2(2*`WIDTH`+1) bits: number of bits shifted since the last load. Saturates at 2*`WIDTH`.
- `frame_done` output, 1 bit: one-cycle pulse when the last frame bit has been shifted past.

## Operation
- **Synchronizers.** `latch` and `pulse` each pass through 2 flops (s1, s2) plus a history flop s3.
  - `lat` = s2 of `latch`.
  - `prise` = s2 & ~s3 of `pulse`.
- **Shift register.** `sr` is 2*`WIDTH` bits. `data_out` is always `sr[MSB]`.
- **Load.** Every cycle that `lat`=1:
  - `sr` <= {positionX, positionY}.
  - `bit_cnt` <= 0.
  - `frame_done` <= 0.
  - Load is transparent: it repeats while `lat` stays high, so changes on positionX/Y are tracked until `lat` falls.
- **Shift.** When `lat`=0 and `prise`=1:
  - `sr` <= {sr[MSB-1:0], IDLE}.
  - If `bit_cnt` < 2*`WIDTH`, increment `bit_cnt`.
  - If `bit_cnt` goes from 2*`WIDTH`-1 to 2*`WIDTH`, assert `frame_done` for exactly one cycle.
- **Bit order.** Frame order is X[7] … X[0], then Y[7] … Y[0]. Two's-complement values are passed through unchanged.
- **Over-clocking.** Pulses beyond 2*`WIDTH` keep shifting `IDLE` in, so `data_out` stays `IDLE`. `bit_cnt` holds at 2*`WIDTH` and `frame_done` does not re-fire.
- **Simultaneous events.**
  - `lat`=1 and `prise`=1 in the same cycle: load wins and no shift occurs.
  - A pulse edge while latch is high is lost; it is not queued.
- **Reset.** Takes effect immediately and asynchronously, including mid-frame. Reset values:
  - `sr` = all `IDLE`, so `data_out` = `IDLE`.
  - `bit_cnt` = 0, `frame_done` = 0.
  - All synchronizer flops = 0.
- **After reset deassert.** The first load needs a fresh latch sample. A pin already high at deassert loads 3 edges later; it is not treated as a missed edge.

## Timing
- Edge k is the first `clk` edge that samples a pin high.
- **Latch to data.** `lat` is high after edge k+1. `sr`, and therefore `data_out`, shows the new MSB after edge k+2, i.e. 3 edges from first sample.
- **Pulse to data.**
  - `prise` is true in the cycle after edge k+1.
  - The shift takes effect at edge k+2.
  - `data_out` shows the next bit after edge k+2.
  - `frame_done` is high for the cycle following edge k+2 of the final pulse.
- **Pin requirements.** Each latch/pulse high or low phase must last at least 2 `clk` periods to be guaranteed seen.
  - The driver must sample `data_in` no earlier than 3 `clk` periods after its own pulse/latch edge.
  - At `CLOCK_50` that is 60 ns. The driver's bit period must exceed 120 ns.
- **Metastability.** s1 may go metastable; only s2 and s3 are used.

## Test plan
- **Reset.** Assert `reset` mid-cycle with `sr` loaded → `data_out`=1, `bit_cnt`=0 and `frame_done`=0 immediately, with no clock needed.
- **Basic frame.** X=8'h5A, Y=8'hFD (-3); latch high 4 cycles then low; 16 pulses, each 5 cycles high / 5 cycles low → sampled stream 0101_1010_1111_1101. `frame_done` pulses once, 3 cycles after the 16th pulse rises. `bit_cnt`=16.
- **Over-clocking.** Continue with 4 extra pulses after the basic frame → `data_out` stays 1, `bit_cnt` stays 16, no further `frame_done`.
- **Transparent load / relatch.**
  - Change X from 8'h5A to 8'h81 while latch is held high → first bit out is 1; stream starts 1000_0001.
  - Relatch after 5 pulses → `bit_cnt` returns to 0 and the stream restarts from X[7].
- **Collision.** Pulse rises the same cycle latch rises (both held 4 cycles) → no shift; `bit_cnt`=0; `data_out`=X[7].
- **Reset mid-frame, then resync.** Pulse `reset` after 7 shifts → `data_out`=1 and `bit_cnt`=0. A new latch with X=8'h00, Y=8'h7F yields 0000_0000_0111_1111.
